// File: rtl/eb1_pkg.sv
// eb1_pkg: trace packet, stored trace record, serializer beat states and header bit positions
package eb1_pkg;

    typedef struct packed {
        logic [31:0] trace_rv_i_insn_ip;
        logic [31:0] trace_rv_i_address_ip;
        logic        trace_rv_i_valid_ip;
        logic        trace_rv_i_exception_ip;
        logic [4:0]  trace_rv_i_ecause_ip;
        logic        trace_rv_i_interrupt_ip;
        logic [31:0] trace_rv_i_tval_ip;
    } eb1_trace_pkt_t;

    typedef struct packed {
        logic        ovf;
        logic        interrupt;
        logic        exception;
        logic [4:0]  ecause;
        logic [31:0] address;
        logic [31:0] insn;
        logic [31:0] tval;
    } eb1_trace_rec_t;

    typedef enum logic [2:0] {IDLE, HDR, ADDR, INSN, TVAL} eb1_trace_beat_e;

    localparam int HDR_OVF       = 31;
    localparam int HDR_INT       = 30;
    localparam int HDR_EXC       = 29;
    localparam int HDR_ECAUSE_HI = 28;
    localparam int HDR_ECAUSE_LO = 24;

endpackage

// File: rtl/eb1_trace_rec_fifo.sv
// eb1_trace_rec_fifo: synchronous FIFO of trace records with flush, occupancy count and head output
// Ports: clk, rst_l (async active-low), push/pop/flush controls, wr_rec in,
//        head_rec (record at read pointer), count (stored records).
module eb1_trace_rec_fifo
    import eb1_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           push,
    input  logic           pop,
    input  logic           flush,
    input  eb1_trace_rec_t wr_rec,
    output eb1_trace_rec_t head_rec,
    output logic [CW-1:0]  count
);

    eb1_trace_rec_t mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_rec;
    end

    assign head_rec = mem[rd_ptr];

endmodule

// File: rtl/eb1_trace_capture_buf.sv
// eb1_trace_capture_buf: captures retired-instruction trace packets and streams them as 32-bit beats
// Ports: clk, rst_l (async active-low), trace_pkt/cap_en capture side, flush (sync clear),
//        rd_valid/rd_ready/rd_data/rd_last reader stream, fifo_count/full occupancy, drop_cnt.
module eb1_trace_capture_buf
    import eb1_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_l,
    input  eb1_trace_pkt_t   trace_pkt,
    input  logic             cap_en,
    input  logic             flush,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      rd_data,
    output logic             rd_last,
    output logic [CW-1:0]    fifo_count,
    output logic             full,
    output logic [CNT_W-1:0] drop_cnt
);

    eb1_trace_beat_e state;
    eb1_trace_beat_e state_nxt;
    eb1_trace_rec_t  head;
    eb1_trace_rec_t  wr_rec;
    logic            ovf_pend;
    logic            pkt_in;
    logic            pkt_xcpt;
    logic            xcpt;
    logic            pop_done;
    logic            push;
    logic            drop;
    logic            more;
    logic [15:0]     hdr_cnt;
    logic [31:0]     hdr;

    assign pkt_in   = cap_en & trace_pkt.trace_rv_i_valid_ip & !flush;
    assign pkt_xcpt = trace_pkt.trace_rv_i_exception_ip | trace_pkt.trace_rv_i_interrupt_ip;
    assign full     = fifo_count == CW'(DEPTH);
    assign pop_done = rd_valid & rd_ready & rd_last;
    assign push     = pkt_in & (!full | pop_done);
    assign drop     = pkt_in & full & !pop_done;
    assign xcpt     = head.exception | head.interrupt;
    // A record pushed in the pop cycle lands at the next read slot, so no bubble is needed.
    assign more     = (fifo_count > CW'(1)) | push;
    assign rd_valid = state != IDLE;
    assign rd_last  = (state == INSN && !xcpt) || state == TVAL;

    always_comb begin
        wr_rec           = '0;
        wr_rec.ovf       = ovf_pend;
        wr_rec.interrupt = trace_pkt.trace_rv_i_interrupt_ip;
        wr_rec.exception = trace_pkt.trace_rv_i_exception_ip;
        wr_rec.ecause    = trace_pkt.trace_rv_i_ecause_ip;
        wr_rec.address   = trace_pkt.trace_rv_i_address_ip;
        wr_rec.insn      = trace_pkt.trace_rv_i_insn_ip;
        wr_rec.tval      = pkt_xcpt ? trace_pkt.trace_rv_i_tval_ip : '0;
    end

    eb1_trace_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_l    (rst_l),
        .push     (push),
        .pop      (pop_done),
        .flush    (flush),
        .wr_rec   (wr_rec),
        .head_rec (head),
        .count    (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = fifo_count != '0 ? HDR : IDLE;
            HDR:     state_nxt = rd_ready ? ADDR : HDR;
            ADDR:    state_nxt = rd_ready ? INSN : ADDR;
            INSN:    state_nxt = !rd_ready ? INSN : xcpt ? TVAL : more ? HDR : IDLE;
            TVAL:    state_nxt = !rd_ready ? TVAL : more ? HDR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hdr                                = '0;
        hdr[HDR_OVF]                       = head.ovf;
        hdr[HDR_INT]                       = head.interrupt;
        hdr[HDR_EXC]                       = head.exception;
        hdr[HDR_ECAUSE_HI:HDR_ECAUSE_LO]   = head.ecause;
        hdr[15:0]                          = hdr_cnt;
        rd_data                            = '0;
        case (state)
            HDR:     rd_data = hdr;
            ADDR:    rd_data = head.address;
            INSN:    rd_data = head.insn;
            TVAL:    rd_data = head.tval;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state    <= IDLE;
            ovf_pend <= 1'b0;
            drop_cnt <= '0;
            hdr_cnt  <= '0;
        end else if (flush) begin
            state    <= IDLE;
            ovf_pend <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (drop) ovf_pend <= 1'b1;
            else if (push) ovf_pend <= 1'b0;
            if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
            // Drop count is frozen while the header beat is presented so a stalled beat stays stable.
            if (state != HDR) hdr_cnt <= 16'(drop_cnt);
        end
    end

endmodule

// File: tb/tb_eb1_trace_capture_buf.sv
// tb_eb1_trace_capture_buf: directed self-checking bench for the trace capture buffer
module tb_eb1_trace_capture_buf;
    import eb1_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic           clk = 1'b0;
    logic           rst_l = 1'b1;
    logic           cap_en = 1'b0;
    logic           flush = 1'b0;
    logic           rd_ready = 1'b0;
    eb1_trace_pkt_t pkt = '0;
    logic           rd_valid;
    logic           rd_last;
    logic           full;
    logic [31:0]    rd_data;
    logic [3:0]     fifo_count;
    logic [15:0]    drop_cnt;
    int             total = 0;
    int             bad = 0;

    always #5 clk = ~clk;

    eb1_trace_capture_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .trace_pkt  (pkt),
        .cap_en     (cap_en),
        .flush      (flush),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .fifo_count (fifo_count),
        .full       (full),
        .drop_cnt   (drop_cnt)
    );

    task automatic set_pkt(input logic [31:0] a, input logic [31:0] i, input logic e,
                           input logic it, input logic [4:0] c, input logic [31:0] t);
        pkt.trace_rv_i_valid_ip     = 1'b1;
        pkt.trace_rv_i_address_ip   = a;
        pkt.trace_rv_i_insn_ip      = i;
        pkt.trace_rv_i_exception_ip = e;
        pkt.trace_rv_i_interrupt_ip = it;
        pkt.trace_rv_i_ecause_ip    = c;
        pkt.trace_rv_i_tval_ip      = t;
    endtask

    task automatic clr_pkt;
        pkt = '0;
    endtask

    // Called at a negedge with rd_ready=1; returns the beat accepted at the next posedge.
    task automatic get_beat(output logic [31:0] d, output logic l, output logic ok);
        ok = 1'b0;
        d  = '0;
        l  = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            if (rd_valid) begin
                d  = rd_data;
                l  = rd_last;
                ok = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1 rst_l = 1'b0;
        #2;
        total++;
        if ({rd_valid, rd_last, full} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=000", {rd_valid, rd_last, full});
        end
        total++;
        if (rd_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=00000000", rd_data);
        end
        total++;
        if (fifo_count !== 4'd0 || drop_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_counts got count=%0d drop=%0d exp 0 0", fifo_count, drop_cnt);
        end
        @(negedge clk);
        rst_l  = 1'b1;
        cap_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        rd_ready = 1'b1;
        set_pkt(32'h8000_0010, 32'h0010_0093, 1'b0, 1'b0, 5'd0, 32'h0000_1234);
        @(negedge clk);
        clr_pkt();
        total++;
        if (rd_valid !== 1'b0 || fifo_count !== 4'd1) begin
            bad++;
            $display("FAIL single_n1 got valid=%b count=%0d exp valid=0 count=1", rd_valid, fifo_count);
        end
        @(negedge clk);
        total++;
        if ({rd_valid, rd_last, rd_data} !== {2'b10, 32'h0000_0000}) begin
            bad++;
            $display("FAIL single_hdr got v=%b l=%b d=%h exp v=1 l=0 d=00000000", rd_valid, rd_last, rd_data);
        end
        @(negedge clk);
        total++;
        if ({rd_valid, rd_last, rd_data} !== {2'b10, 32'h8000_0010}) begin
            bad++;
            $display("FAIL single_addr got v=%b l=%b d=%h exp v=1 l=0 d=80000010", rd_valid, rd_last, rd_data);
        end
        @(negedge clk);
        total++;
        if ({rd_valid, rd_last, rd_data} !== {2'b11, 32'h0010_0093}) begin
            bad++;
            $display("FAIL single_insn got v=%b l=%b d=%h exp v=1 l=1 d=00100093", rd_valid, rd_last, rd_data);
        end
        @(negedge clk);
        total++;
        if (rd_valid !== 1'b0 || fifo_count !== 4'd0) begin
            bad++;
            $display("FAIL single_end got valid=%b count=%0d exp valid=0 count=0", rd_valid, fifo_count);
        end
    endtask

    task automatic test_exception;
        logic [31:0] d;
        logic        l;
        logic        ok;
        logic [31:0] exp_d [4];
        logic        exp_l [4];
        exp_d = '{32'h2200_0000, 32'h8000_0020, 32'h0000_0073, 32'hDEAD_BEEF};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        rd_ready = 1'b1;
        set_pkt(32'h8000_0020, 32'h0000_0073, 1'b1, 1'b0, 5'd2, 32'hDEAD_BEEF);
        @(negedge clk);
        clr_pkt();
        for (int k = 0; k < 4; k++) begin
            get_beat(d, l, ok);
            total++;
            if (!ok || d !== exp_d[k] || l !== exp_l[k]) begin
                bad++;
                $display("FAIL exc_beat%0d got ok=%b d=%h l=%b exp d=%h l=%b", k, ok, d, l, exp_d[k], exp_l[k]);
            end
        end
        total++;
        if (rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL exc_end got valid=%b exp 0", rd_valid);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] b [3];
        logic        l [3];
        logic        ok;
        logic        all_ok;
        rd_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            set_pkt(32'h1000 + i, 32'h2000 + i, 1'b0, 1'b0, 5'd0, 32'h0);
            @(negedge clk);
        end
        clr_pkt();
        total++;
        if (full !== 1'b1 || drop_cnt !== 16'd3 || fifo_count !== 4'd8) begin
            bad++;
            $display("FAIL ovf_state got full=%b drop=%0d count=%0d exp 1 3 8", full, drop_cnt, fifo_count);
        end
        rd_ready = 1'b1;
        for (int r = 0; r < DEPTH; r++) begin
            all_ok = 1'b1;
            for (int k = 0; k < 3; k++) begin
                get_beat(b[k], l[k], ok);
                all_ok &= ok;
            end
            total++;
            if (!all_ok || b[0][31] !== 1'b0 || b[1] !== 32'h1000 + r || b[2] !== 32'h2000 + r || l[2] !== 1'b1) begin
                bad++;
                $display("FAIL ovf_rec%0d got ok=%b hdr=%h addr=%h insn=%h last=%b exp ovf=0 addr=%h insn=%h last=1",
                         r, all_ok, b[0], b[1], b[2], l[2], 32'h1000 + r, 32'h2000 + r);
            end
        end
        total++;
        if (rd_valid !== 1'b0 || fifo_count !== 4'd0) begin
            bad++;
            $display("FAIL ovf_drained got valid=%b count=%0d exp 0 0", rd_valid, fifo_count);
        end
        set_pkt(32'h3000, 32'h4000, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        clr_pkt();
        all_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            get_beat(b[k], l[k], ok);
            all_ok &= ok;
        end
        total++;
        if (!all_ok || b[0] !== 32'h8000_0003 || b[1] !== 32'h3000) begin
            bad++;
            $display("FAIL ovf_mark got ok=%b hdr=%h addr=%h exp hdr=80000003 addr=00003000", all_ok, b[0], b[1]);
        end
    endtask

    task automatic test_flush;
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_pkt(32'h5000 + i, 32'h5100 + i, 1'b0, 1'b0, 5'd0, 32'h0);
            @(negedge clk);
        end
        clr_pkt();
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h5000 || fifo_count !== 4'd3 || drop_cnt !== 16'd3) begin
            bad++;
            $display("FAIL flush_pre got v=%b d=%h count=%0d drop=%0d exp 1 00005000 3 3",
                     rd_valid, rd_data, fifo_count, drop_cnt);
        end
        flush = 1'b1;
        set_pkt(32'h6000, 32'h6100, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        flush = 1'b0;
        clr_pkt();
        total++;
        if (rd_valid !== 1'b0 || fifo_count !== 4'd0 || drop_cnt !== 16'd0 || full !== 1'b0) begin
            bad++;
            $display("FAIL flush_clear got v=%b count=%0d drop=%0d full=%b exp 0 0 0 0",
                     rd_valid, fifo_count, drop_cnt, full);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (rd_valid !== 1'b0 || fifo_count !== 4'd0) begin
            bad++;
            $display("FAIL flush_discard got v=%b count=%0d exp 0 0", rd_valid, fifo_count);
        end
    endtask

    task automatic test_full_pop;
        logic [31:0] b [3];
        logic        l [3];
        logic        ok;
        logic        all_ok;
        logic [31:0] exp_a;
        rd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_pkt(32'h7000 + i, 32'h7800 + i, 1'b0, 1'b0, 5'd0, 32'h0);
            @(negedge clk);
        end
        clr_pkt();
        rd_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (full !== 1'b1 || rd_last !== 1'b1 || rd_data !== 32'h7800) begin
            bad++;
            $display("FAIL fullpop_pre got full=%b last=%b d=%h exp 1 1 00007800", full, rd_last, rd_data);
        end
        set_pkt(32'h7100, 32'h7900, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        clr_pkt();
        total++;
        if (fifo_count !== 4'd8 || drop_cnt !== 16'd0 || full !== 1'b1) begin
            bad++;
            $display("FAIL fullpop_push got count=%0d drop=%0d full=%b exp 8 0 1", fifo_count, drop_cnt, full);
        end
        for (int r = 0; r < DEPTH; r++) begin
            all_ok = 1'b1;
            for (int k = 0; k < 3; k++) begin
                get_beat(b[k], l[k], ok);
                all_ok &= ok;
            end
            exp_a = (r < DEPTH - 1) ? 32'h7001 + r : 32'h7100;
            total++;
            if (!all_ok || b[0] !== 32'h0 || b[1] !== exp_a) begin
                bad++;
                $display("FAIL fullpop_rec%0d got ok=%b hdr=%h addr=%h exp hdr=00000000 addr=%h", r, all_ok, b[0], b[1], exp_a);
            end
        end
    endtask

    task automatic test_toggle;
        logic [32:0] expq [$];
        logic [32:0] e;
        logic        ex;
        logic        it;
        logic [4:0]  c;
        logic        stalled;
        logic [31:0] pd;
        logic        pl;
        int          sent;
        int          got;
        int          nexp;
        for (int j = 0; j < 20; j++) begin
            ex = (j % 3) == 1;
            it = (j % 5) == 4;
            c  = (ex | it) ? 5'(j) : 5'd0;
            expq.push_back({1'b0, 1'b0, it, ex, c, 8'h0, 16'h0});
            expq.push_back({1'b0, 32'h9000_0000 + 32'(j * 4)});
            expq.push_back({!(ex | it), 32'hA000 + 32'(j)});
            if (ex | it) expq.push_back({1'b1, 32'hB000_0000 + 32'(j)});
        end
        nexp    = expq.size();
        sent    = 0;
        got     = 0;
        stalled = 1'b0;
        pd      = '0;
        pl      = 1'b0;
        rd_ready = 1'b0;
        for (int cyc = 0; cyc < 2000 && expq.size() != 0; cyc++) begin
            if (stalled) begin
                total++;
                if (rd_valid !== 1'b1 || rd_data !== pd || rd_last !== pl) begin
                    bad++;
                    $display("FAIL tog_stable got v=%b d=%h l=%b exp v=1 d=%h l=%b", rd_valid, rd_data, rd_last, pd, pl);
                end
            end
            rd_ready = ~rd_ready;
            if (rd_valid && rd_ready) begin
                e = expq.pop_front();
                got++;
                total++;
                if ({rd_last, rd_data} !== e) begin
                    bad++;
                    $display("FAIL tog_beat%0d got l=%b d=%h exp l=%b d=%h", got, rd_last, rd_data, e[32], e[31:0]);
                end
            end
            stalled = rd_valid && !rd_ready;
            pd      = rd_data;
            pl      = rd_last;
            if (sent < 20 && !full) begin
                ex = (sent % 3) == 1;
                it = (sent % 5) == 4;
                c  = (ex | it) ? 5'(sent) : 5'd0;
                set_pkt(32'h9000_0000 + 32'(sent * 4), 32'hA000 + 32'(sent), ex, it, c, 32'hB000_0000 + 32'(sent));
                sent++;
            end else begin
                clr_pkt();
            end
            @(negedge clk);
        end
        clr_pkt();
        rd_ready = 1'b1;
        total++;
        if (got !== nexp) begin
            bad++;
            $display("FAIL tog_count got=%0d exp=%0d", got, nexp);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (rd_valid !== 1'b0 || fifo_count !== 4'd0) begin
            bad++;
            $display("FAIL tog_end got v=%b count=%0d exp 0 0", rd_valid, fifo_count);
        end
    endtask

    task automatic test_cap_en;
        logic [31:0] b [3];
        logic        l [3];
        logic        ok;
        logic        all_ok;
        rd_ready = 1'b0;
        set_pkt(32'hE000, 32'hE100, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        cap_en = 1'b0;
        set_pkt(32'hF000, 32'hF100, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        clr_pkt();
        @(negedge clk);
        total++;
        if (fifo_count !== 4'd1 || drop_cnt !== 16'd0) begin
            bad++;
            $display("FAIL capen_ignore got count=%0d drop=%0d exp 1 0", fifo_count, drop_cnt);
        end
        rd_ready = 1'b1;
        all_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            get_beat(b[k], l[k], ok);
            all_ok &= ok;
        end
        total++;
        if (!all_ok || b[1] !== 32'hE000 || l[2] !== 1'b1 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL capen_drain got ok=%b addr=%h last=%b v=%b exp addr=0000e000 last=1 v=0",
                     all_ok, b[1], l[2], rd_valid);
        end
        cap_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        logic seen;
        rd_ready = 1'b1;
        set_pkt(32'hC000, 32'hC004, 1'b0, 1'b1, 5'd7, 32'h1111_2222);
        @(negedge clk);
        set_pkt(32'hC010, 32'hC014, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        clr_pkt();
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (rd_valid && rd_last && rd_data == 32'h1111_2222) begin
                seen = 1'b1;
                rd_ready = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        total++;
        if (!seen || fifo_count !== 4'd2) begin
            bad++;
            $display("FAIL rstmid_tval got seen=%b count=%0d exp 1 2", seen, fifo_count);
        end
        #2 rst_l = 1'b0;
        #1;
        total++;
        if ({rd_valid, rd_last, full} !== 3'b000 || rd_data !== 32'h0 || fifo_count !== 4'd0 || drop_cnt !== 16'd0) begin
            bad++;
            $display("FAIL rstmid_async got v=%b l=%b full=%b d=%h count=%0d drop=%0d exp all 0",
                     rd_valid, rd_last, full, rd_data, fifo_count, drop_cnt);
        end
        @(negedge clk);
        rst_l    = 1'b1;
        rd_ready = 1'b1;
        seen     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (rd_valid) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_nobeat got valid seen=%b exp 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_exception();
        test_overflow();
        test_flush();
        test_full_pop();
        test_toggle();
        test_cap_en();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/eb1_trace_capture_buf.md
Name: eb1_trace_capture_buf

Overview:
- Receiving end of the core's instruction-trace packet (eb1_trace_pkt_t).
- Captures retired-instruction trace records into a small FIFO.
- A debug/trace-port reader drains the records as a 32-bit word stream with valid/ready handshake: 3 beats per record, 4 if exception or interrupt.
- Sits between the core trace outputs and the SoC trace sink; counts records dropped on overflow.

Parameters:
- DEPTH, 8, number of record entries; power of two, 2..64.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  core clock.
- rst_l  in  1  asynchronous active-low reset.
- trace_pkt  in  eb1_trace_pkt_t  trace packet from core; sampled when trace_rv_i_valid_ip=1.
- cap_en  in  1  capture enable; packets are ignored while 0 (not counted as drops).
- flush  in  1  synchronous clear of FIFO, serializer and drop counter.
- rd_valid  out  1  rd_data holds a valid beat.
- rd_ready  in  1  reader accepts the beat.
- rd_data  out  32  beat payload.
- rd_last  out  1  final beat of the current record.
- fifo_count  out  $clog2(DEPTH)+1  stored records, including the one being serialized.
- full  out  1  fifo_count==DEPTH.
- drop_cnt  out  CNT_W  saturating count of dropped packets.

Behaviour:
- Reset (rst_l=0, async) values: rd_valid=0, rd_last=0, rd_data=0, fifo_count=0, full=0, drop_cnt=0; serializer state=IDLE; ovf_pend=0.
- Push: cap_en & valid_ip & (!full | pop_done). pop_done = rd_valid & rd_ready & rd_last.
  - Stored record: {ovf, interrupt, exception, ecause[4:0], address[31:0], insn[31:0], tval[31:0]}.
  - ovf = ovf_pend; ovf_pend clears on that push.
- Drop: cap_en & valid_ip & full & !pop_done. Increments drop_cnt, saturating at all-ones, and sets ovf_pend.
- Push of an exception/interrupt packet with tval stores tval. Otherwise tval is stored as 0 and not emitted.
- Serializer FSM:
  - IDLE -> HDR when the FIFO is non-empty. The head record is readable from the next cycle.
  - HDR: rd_data = {ovf, interrupt, exception, ecause, 8'h0, drop_cnt[15:0]}. If CNT_W<16, drop_cnt is zero-extended. Advances to ADDR on handshake.
  - ADDR: rd_data = address. Advances to INSN.
  - INSN: rd_data = insn. rd_last = !(exception|interrupt). On handshake with rd_last, goes to HDR if more records are pending, else IDLE.
  - TVAL: rd_data = tval, rd_last=1. Same exit as INSN.
- Minimum latency: packet on cycle N -> rd_valid=1 with its HDR at N+2 (FIFO write at N+1 edge, FSM entry at N+2 edge).
- Back-to-back records: no bubble between the last beat of one record and the HDR of the next.
- rd_valid/rd_data/rd_last stay stable while rd_valid & !rd_ready (AXI-style). rd_valid never drops without a handshake except on flush/reset.
- The FIFO entry is freed only on pop_done. A partially serialized record keeps its slot. fifo_count reflects push/pop in the same cycle (net 0).
- Wrap-around: read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Full/empty are derived from fifo_count.
- flush has priority over push, pop and drop in the same cycle. Next cycle: FIFO empty, FSM IDLE, rd_valid=0, drop_cnt=0, ovf_pend=0. A packet arriving in the flush cycle is discarded.
- cap_en deasserted mid-stream: records already stored continue to drain.
- Reset mid-record: the record is lost. No partial beats after reset.

Decomposition:
- Add to eb1_pkg:
  - eb1_trace_rec_t, the packed stored-record struct.
  - eb1_trace_beat_e, the enum IDLE/HDR/ADDR/INSN/TVAL.
  - Header bit-position localparams: OVF=31, INT=30, EXC=29, ECAUSE=28:24.
- One sub-module, eb1_trace_rec_fifo: parameterized synchronous FIFO of eb1_trace_rec_t with push/pop/flush, count, and head-record output.
- Serializer FSM and drop logic stay in the top.

Test Plan:
- Single non-exception packet (addr=32'h8000_0010, insn=32'h0010_0093), rd_ready=1 -> 3 beats: HDR=32'h0000_0000, 32'h8000_0010, 32'h0010_0093; rd_last on beat 3; HDR appears 2 cycles after input.
- Exception packet (ecause=5'd2, tval=32'hDEAD_BEEF) -> 4 beats; HDR[29]=1, HDR[28:24]=2; beat 4 = 32'hDEAD_BEEF with rd_last=1.
- rd_ready=0, push DEPTH+3 packets -> full=1, drop_cnt=3. First record pushed after drain has HDR[31]=1 and HDR[15:0]=3. All earlier records have HDR[31]=0.
- Full FIFO, push coincides with pop_done -> packet accepted, drop_cnt unchanged, fifo_count stays DEPTH.
- rd_ready toggled 1/0 every cycle over 20 records -> rd_data stable while stalled, no beat lost or duplicated, pointer wrap exercised twice.
- flush asserted during ADDR beat with 3 records queued -> next cycle rd_valid=0, fifo_count=0, drop_cnt=0. Separately, rst_l pulsed low mid-TVAL -> all outputs return to reset values asynchronously.
